// File: rtl/serial_edge_tx_pkg.sv
// Shared types for the serial edge transmitter.
// Holds the FSM state encoding used by the top level.
package serial_edge_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/serial_edge_counter.sv
// Counts rising/falling transitions on a single-bit line; clear re-arms from INIT_LVL.
// Outputs include the current enabled sample, so a frame total is valid in its last bit cycle.
module serial_edge_counter #(
  parameter int   CW       = 5,
  parameter logic INIT_LVL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          din_i,
  output logic [CW-1:0] rise_o,
  output logic [CW-1:0] fall_o
);

  logic          prev_q;
  logic [CW-1:0] rise_q;
  logic [CW-1:0] fall_q;

  always_comb begin
    rise_o = rise_q;
    fall_o = fall_q;
    if (en_i && !clr_i) begin
      if (din_i && !prev_q) rise_o = rise_q + CW'(1);
      if (!din_i && prev_q) fall_o = fall_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= INIT_LVL;
      rise_q <= '0;
      fall_q <= '0;
    end else if (clr_i) begin
      prev_q <= INIT_LVL;
      rise_q <= '0;
      fall_q <= '0;
    end else if (en_i) begin
      prev_q <= din_i;
      rise_q <= rise_o;
      fall_q <= fall_o;
    end
  end

endmodule

// File: rtl/serial_edge_tx.sv
// MSB-first serial pattern transmitter with forced idle gap and per-frame edge counts.
// Accept-to-first-bit latency is one cycle; load_valid is ignored while busy (no buffering).
module serial_edge_tx
  import serial_edge_tx_pkg::*;
#(
  parameter int   WIDTH    = 21,
  parameter int   GAP      = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           load_data,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic                       abort,
  output logic                       dout,
  output logic                       dout_valid,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] rise_cnt,
  output logic [$clog2(WIDTH+1)-1:0] fall_cnt
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [GW-1:0]    gapcnt_q, gapcnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_ready_q, load_ready_d;
  logic [CW-1:0]    rise_q, rise_d;
  logic [CW-1:0]    fall_q, fall_d;
  logic             cnt_clr;
  logic [CW-1:0]    rise_run, fall_run;

  // Watches the registered line, so the running count covers exactly the frame bits.
  serial_edge_counter #(
    .CW       (CW),
    .INIT_LVL (IDLE_LVL)
  ) u_edge_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (dout_valid_q),
    .din_i  (dout_q),
    .rise_o (rise_run),
    .fall_o (fall_run)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    gapcnt_d     = gapcnt_q;
    dout_d       = IDLE_LVL;
    dout_valid_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    load_ready_d = 1'b0;
    rise_d       = rise_q;
    fall_d       = fall_q;
    cnt_clr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_ready_d = 1'b1;
        if (load_valid && !abort) begin
          state_d      = ST_SHIFT;
          dout_d       = load_data[WIDTH-1];
          dout_valid_d = 1'b1;
          busy_d       = 1'b1;
          load_ready_d = 1'b0;
          shreg_d      = {load_data[WIDTH-2:0], 1'b0};
          bitcnt_d     = CW'(WIDTH-1);
          cnt_clr      = 1'b1;
        end
      end
      ST_SHIFT: begin
        busy_d = 1'b1;
        if (abort) begin
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          load_ready_d = 1'b1;
        end else if (bitcnt_q != '0) begin
          dout_d       = shreg_q[WIDTH-1];
          dout_valid_d = 1'b1;
          shreg_d      = {shreg_q[WIDTH-2:0], 1'b0};
          bitcnt_d     = bitcnt_q - CW'(1);
        end else begin
          // Last bit is on the line now; publish counts alongside done.
          done_d = 1'b1;
          rise_d = rise_run;
          fall_d = fall_run;
          if (GAP == 0) begin
            state_d      = ST_IDLE;
            busy_d       = 1'b0;
            load_ready_d = 1'b1;
          end else begin
            state_d  = ST_GAP;
            gapcnt_d = GW'(GAP-1);
          end
        end
      end
      ST_GAP: begin
        busy_d = 1'b1;
        if (abort || gapcnt_q == '0) begin
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          load_ready_d = 1'b1;
        end else begin
          gapcnt_d = gapcnt_q - GW'(1);
        end
      end
      default: begin
        state_d      = ST_IDLE;
        load_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      gapcnt_q     <= '0;
      dout_q       <= IDLE_LVL;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
      rise_q       <= '0;
      fall_q       <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      gapcnt_q     <= gapcnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
    end
  end

  assign load_ready = load_ready_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rise_cnt   = rise_q;
  assign fall_cnt   = fall_q;

endmodule
